// File: rtl/jtoutrun_subarb_pkg.sv
// Shared definitions for the OutRun main-to-sub bus arbiter.
// State encoding and the idle value of the sub-bus data strobes.
package jtoutrun_subarb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        GRANT = 3'd2,
        CYCLE = 3'd3,
        HOLD  = 3'd4
    } state_t;

    // Data strobes are active low: both high means no byte lane selected.
    localparam logic [1:0] DSN_IDLE = 2'b11;

endpackage

// File: rtl/jtoutrun_subarb.sv
// Main-to-sub shared-bus arbiter for OutRun.
// Takes a sub-bus request from the main CPU, performs the 68000
// BR/BG/BGACK handshake with the sub CPU, runs one cycle on the sub bus
// and returns data plus an acknowledge to the main side.
// Optional build macro JTOUTRUN_SUBARB_WDOG_EN adds a grant watchdog that
// completes the access with 16'hFFFF and raises a sticky wdog_flag when the
// sub CPU never grants the bus.
module jtoutrun_subarb
    import jtoutrun_subarb_pkg::*;
#(
    parameter int AW     = 18,
    parameter int WDOG_W = 10
) (
    input  logic          clk,
    input  logic          rst,
    // main CPU side
    input  logic          main_req,
    input  logic [AW-1:0] main_addr,
    input  logic [1:0]    main_dsn,
    input  logic          main_rnw,
    input  logic [15:0]   main_dout,
    output logic          main_ok,
    output logic [15:0]   main_din,
    // sub CPU bus arbitration
    input  logic          sub_asn,
    input  logic          sub_bgn,
    output logic          sub_brn,
    output logic          sub_bgackn,
    // sub bus master port
    output logic          bus_own,
    output logic [AW-1:0] bus_addr,
    output logic [1:0]    bus_dsn,
    output logic          bus_rnw,
    output logic [15:0]   bus_dout,
    output logic          bus_cs,
    input  logic          bus_ok,
    input  logic [15:0]   bus_din,
    // diagnostics
    output logic          wdog_flag
);

    state_t        state_r, state_s;

    logic          sub_brn_r,    sub_brn_s;
    logic          sub_bgackn_r, sub_bgackn_s;
    logic          main_ok_r,    main_ok_s;
    logic [15:0]   main_din_r,   main_din_s;
    logic          bus_own_r,    bus_own_s;
    logic          bus_cs_r,     bus_cs_s;
    logic [1:0]    bus_dsn_r,    bus_dsn_s;
    logic          bus_rnw_r,    bus_rnw_s;
    logic [AW-1:0] bus_addr_r,   bus_addr_s;
    logic [15:0]   bus_dout_r,   bus_dout_s;

    logic          grant_s;
    logic          wdog_hit_s;

    // The sub CPU has given the bus away only once BG is low and it has
    // finished its own cycle (AS high) on the same edge.
    assign grant_s = ~sub_bgn & sub_asn;

`ifdef JTOUTRUN_SUBARB_WDOG_EN
    localparam logic [WDOG_W-1:0] WDOG_LAST = {{(WDOG_W-1){1'b1}}, 1'b0};

    logic [WDOG_W-1:0] wdog_cnt_r;
    logic              wdog_flag_r;

    // Timeout fires on the edge where the counter would reach all-ones.
    assign wdog_hit_s = (state_r == REQ) && (wdog_cnt_r == WDOG_LAST);

    // Grant watchdog: held at zero outside REQ, counts clocks spent in REQ.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt_r <= {WDOG_W{1'b0}};
        end else if (state_r != REQ) begin
            wdog_cnt_r <= {WDOG_W{1'b0}};
        end else begin
            wdog_cnt_r <= wdog_cnt_r + {{(WDOG_W-1){1'b0}}, 1'b1};
        end
    end

    // Sticky timeout flag, only cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_flag_r <= 1'b0;
        end else if (wdog_hit_s && main_req && !grant_s) begin
            wdog_flag_r <= 1'b1;
        end else begin
            wdog_flag_r <= wdog_flag_r;
        end
    end

    assign wdog_flag = wdog_flag_r;
`else
    assign wdog_hit_s = 1'b0;
    assign wdog_flag  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; an abort in REQ wins over a grant on the same edge.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (main_req && !main_ok_r) begin
                    state_s = REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (!main_req) begin
                    state_s = IDLE;
                end else if (grant_s) begin
                    state_s = GRANT;
                end else if (wdog_hit_s) begin
                    state_s = HOLD;
                end else begin
                    state_s = REQ;
                end
            end
            GRANT: begin
                state_s = CYCLE;
            end
            CYCLE: begin
                if (bus_ok) begin
                    state_s = main_req ? HOLD : IDLE;
                end else begin
                    state_s = CYCLE;
                end
            end
            HOLD: begin
                if (!main_req) begin
                    state_s = IDLE;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs for the current state and inputs.
    always_comb begin
        sub_brn_s    = sub_brn_r;
        sub_bgackn_s = sub_bgackn_r;
        main_ok_s    = main_ok_r;
        main_din_s   = main_din_r;
        bus_own_s    = bus_own_r;
        bus_cs_s     = bus_cs_r;
        bus_dsn_s    = bus_dsn_r;
        bus_rnw_s    = bus_rnw_r;
        bus_addr_s   = bus_addr_r;
        bus_dout_s   = bus_dout_r;
        case (state_r)
            IDLE: begin
                if (main_req && !main_ok_r) begin
                    sub_brn_s = 1'b0;
                end else begin
                    sub_brn_s = 1'b1;
                end
            end
            REQ: begin
                if (!main_req) begin
                    sub_brn_s = 1'b1;
                end else if (grant_s) begin
                    sub_brn_s = 1'b0;
                end else if (wdog_hit_s) begin
                    sub_brn_s  = 1'b1;
                    main_din_s = 16'hFFFF;
                    main_ok_s  = 1'b1;
                end else begin
                    sub_brn_s = 1'b0;
                end
            end
            GRANT: begin
                // Take the bus and freeze the main CPU's cycle fields.
                sub_bgackn_s = 1'b0;
                sub_brn_s    = 1'b1;
                bus_own_s    = 1'b1;
                bus_cs_s     = 1'b1;
                bus_addr_s   = main_addr;
                bus_dsn_s    = main_dsn;
                bus_rnw_s    = main_rnw;
                bus_dout_s   = main_dout;
            end
            CYCLE: begin
                if (bus_ok) begin
                    bus_cs_s  = 1'b0;
                    bus_dsn_s = DSN_IDLE;
                    if (bus_rnw_r) begin
                        main_din_s = bus_din;
                    end else begin
                        main_din_s = main_din_r;
                    end
                    if (main_req) begin
                        main_ok_s = 1'b1;
                    end else begin
                        // Requester gave up: finish silently and hand back.
                        main_ok_s    = 1'b0;
                        sub_bgackn_s = 1'b1;
                        bus_own_s    = 1'b0;
                    end
                end else begin
                    bus_cs_s = 1'b1;
                end
            end
            HOLD: begin
                if (!main_req) begin
                    main_ok_s    = 1'b0;
                    sub_bgackn_s = 1'b1;
                    bus_own_s    = 1'b0;
                end else begin
                    main_ok_s = 1'b1;
                end
            end
            default: begin
                sub_brn_s    = 1'b1;
                sub_bgackn_s = 1'b1;
                main_ok_s    = 1'b0;
                bus_own_s    = 1'b0;
                bus_cs_s     = 1'b0;
                bus_dsn_s    = DSN_IDLE;
            end
        endcase
    end

    // Output registers; reset drops any grant in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            sub_brn_r    <= 1'b1;
            sub_bgackn_r <= 1'b1;
            main_ok_r    <= 1'b0;
            main_din_r   <= 16'h0000;
            bus_own_r    <= 1'b0;
            bus_cs_r     <= 1'b0;
            bus_dsn_r    <= DSN_IDLE;
            bus_rnw_r    <= 1'b1;
            bus_addr_r   <= {AW{1'b0}};
            bus_dout_r   <= 16'h0000;
        end else begin
            sub_brn_r    <= sub_brn_s;
            sub_bgackn_r <= sub_bgackn_s;
            main_ok_r    <= main_ok_s;
            main_din_r   <= main_din_s;
            bus_own_r    <= bus_own_s;
            bus_cs_r     <= bus_cs_s;
            bus_dsn_r    <= bus_dsn_s;
            bus_rnw_r    <= bus_rnw_s;
            bus_addr_r   <= bus_addr_s;
            bus_dout_r   <= bus_dout_s;
        end
    end

    assign sub_brn    = sub_brn_r;
    assign sub_bgackn = sub_bgackn_r;
    assign main_ok    = main_ok_r;
    assign main_din   = main_din_r;
    assign bus_own    = bus_own_r;
    assign bus_cs     = bus_cs_r;
    assign bus_dsn    = bus_dsn_r;
    assign bus_rnw    = bus_rnw_r;
    assign bus_addr   = bus_addr_r;
    assign bus_dout   = bus_dout_r;

endmodule
